// File: rtl/led_pattern_seq_if.sv
// Mode/divisor inputs and LED/status outputs of the LED pattern sequencer.
// The master side drives the selectors; the slave side is the sequencer.
interface led_pattern_seq_if #(
  parameter int N_LED = 8,
  parameter int DIV_W = 24,
  parameter int CNT_W = 4
);
  logic [2:0]       mode;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] blink_limit;
  logic [N_LED-1:0] led;
  logic             tick;
  logic             done;

  modport master (
    output mode, div, blink_limit,
    input  led, tick, done
  );

  modport slave (
    input  mode, div, blink_limit,
    output led, tick, done
  );
endinterface

// File: rtl/led_pattern_seq.sv
// N-LED pattern sequencer: step prescaler, timed pulse with completion flag,
// sweep/fill/converge/hazard/static patterns; a mode change restarts from blank.
module led_pattern_seq #(
  parameter int               N_LED      = 8,
  parameter int               DIV_W      = 24,
  parameter int               CNT_W      = 4,
  parameter logic [N_LED-1:0] BLINK_PAT  = '1,
  parameter logic [N_LED-1:0] STATIC_PAT = N_LED'(8'b10100101)
) (
  input logic              clk,
  input logic              rst_n,
  led_pattern_seq_if.slave bus
);
  localparam int H     = N_LED / 2;
  localparam int IDX_W = $clog2(H + 1);

  logic [2:0]       mode_q;
  logic [DIV_W-1:0] presc;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] bcnt;
  logic [N_LED-1:0] led_p0;
  logic             tick_p0;
  logic             done_p0;
  logic [IDX_W-1:0] idx_nxt;
  int               k;

  assign idx_nxt = (idx == IDX_W'(H)) ? '0 : idx + 1'b1;
  assign k       = int'(idx_nxt);

  // Each pattern is blank at position 0 so every cycle begins with all LEDs off.
  function automatic logic [N_LED-1:0] sweep_r(input int p);
    logic [N_LED-1:0] r;
    for (int b = 0; b < N_LED; b++) r[b] = (p != 0) && (b == H - p);
    return r;
  endfunction

  function automatic logic [N_LED-1:0] sweep_l(input int p);
    logic [N_LED-1:0] r;
    for (int b = 0; b < N_LED; b++) r[b] = (p != 0) && (b == H - 1 + p);
    return r;
  endfunction

  function automatic logic [N_LED-1:0] fill_r(input int p);
    logic [N_LED-1:0] r;
    for (int b = 0; b < N_LED; b++) r[b] = (p != 0) && (b >= H - p) && (b < H);
    return r;
  endfunction

  function automatic logic [N_LED-1:0] converge(input int p);
    logic [N_LED-1:0] r;
    for (int b = 0; b < N_LED; b++) r[b] = (p != 0) && ((b == p - 1) || (b == N_LED - p));
    return r;
  endfunction

  // Stage p0: mode tracking, prescaler and pattern registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= '0;
      presc   <= '0;
      idx     <= '0;
      bcnt    <= '0;
      led_p0  <= '0;
      tick_p0 <= 1'b0;
      done_p0 <= 1'b0;
    end else if (bus.mode != mode_q) begin
      mode_q  <= bus.mode;
      presc   <= '0;
      idx     <= '0;
      bcnt    <= '0;
      led_p0  <= '0;
      tick_p0 <= 1'b0;
      done_p0 <= 1'b0;
    end else if (presc >= bus.div) begin
      // >= rather than == so a lowered div steps immediately instead of wrapping
      presc   <= '0;
      tick_p0 <= 1'b1;
      case (mode_q)
        3'b000: led_p0 <= '0;
        3'b001: begin
          if (bcnt < bus.blink_limit) begin
            led_p0 <= BLINK_PAT;
            bcnt   <= bcnt + 1'b1;
          end else begin
            led_p0  <= '0;
            done_p0 <= 1'b1;
          end
        end
        3'b010: begin
          idx    <= idx_nxt;
          led_p0 <= sweep_r(k);
        end
        3'b011: begin
          idx    <= idx_nxt;
          led_p0 <= sweep_l(k);
        end
        3'b100: led_p0 <= (led_p0 == BLINK_PAT) ? '0 : BLINK_PAT;
        3'b101: begin
          idx    <= idx_nxt;
          led_p0 <= fill_r(k);
        end
        3'b110: begin
          idx    <= idx_nxt;
          led_p0 <= converge(k);
        end
        3'b111: led_p0 <= STATIC_PAT;
      endcase
    end else begin
      presc   <= presc + 1'b1;
      tick_p0 <= 1'b0;
    end
  end

  assign bus.led  = led_p0;
  assign bus.tick = tick_p0;
  assign bus.done = done_p0;
endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed, table-driven bench for led_pattern_seq at N_LED=8.
module tb_led_pattern_seq;
  logic clk = 1'b0;
  logic rst_n;

  led_pattern_seq_if #(.N_LED(8), .DIV_W(24), .CNT_W(4)) bus ();

  led_pattern_seq #(.N_LED(8), .DIV_W(24), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [2:0]  mode;
    logic [23:0] div;
    logic [3:0]  bl;
    logic [7:0]  led;
    logic        tick;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic [2:0] m, input logic [23:0] d,
                     input logic [3:0] b, input logic [7:0] l, input logic t,
                     input logic dn);
    vec_t v;
    v.rst_n = r; v.mode = m; v.div = d; v.bl = b;
    v.led = l; v.tick = t; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] m, input logic [23:0] d,
                      input logic [3:0] b);
    rst_n = r; bus.mode = m; bus.div = d; bus.blink_limit = b;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pats[6];
  logic [7:0] prev;

  initial begin
    rst_n = 1'b0; bus.mode = 3'b010; bus.div = 24'd2; bus.blink_limit = 4'd0;

    // Reset held 3 cycles with a sweep mode already selected
    for (int i = 0; i < 3; i++) add(0, 3'b010, 2, 0, 8'h00, 0, 0);
    // Release: one mode-change cycle, then sweep right every 3 cycles
    add(1, 3'b010, 2, 0, 8'h00, 0, 0);
    pats = '{8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h08};
    prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      add(1, 3'b010, 2, 0, prev, 0, 0);
      add(1, 3'b010, 2, 0, prev, 0, 0);
      add(1, 3'b010, 2, 0, pats[i], 1, 0);
      prev = pats[i];
    end
    // Timed pulse, limit 3, div 0
    add(1, 3'b001, 0, 3, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 3'b001, 0, 3, 8'hFF, 1, 0);
    add(1, 3'b001, 0, 3, 8'h00, 1, 1);
    add(1, 3'b001, 0, 3, 8'h00, 1, 1);
    add(1, 3'b001, 0, 3, 8'h00, 1, 1);
    // Leaving the mode clears done
    add(1, 3'b000, 0, 3, 8'h00, 0, 0);
    add(1, 3'b000, 0, 3, 8'h00, 1, 0);
    // Limit 0: done at the very first step
    add(1, 3'b001, 0, 0, 8'h00, 0, 0);
    add(1, 3'b001, 0, 0, 8'h00, 1, 1);
    // Converge
    add(1, 3'b110, 0, 0, 8'h00, 0, 0);
    pats = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h00, 8'h81};
    for (int i = 0; i < 6; i++) add(1, 3'b110, 0, 0, pats[i], 1, 0);
    // Fill right
    add(1, 3'b101, 0, 0, 8'h00, 0, 0);
    pats = '{8'h08, 8'h0C, 8'h0E, 8'h0F, 8'h00, 8'h08};
    for (int i = 0; i < 6; i++) add(1, 3'b101, 0, 0, pats[i], 1, 0);
    // Static
    add(1, 3'b111, 0, 0, 8'h00, 0, 0);
    add(1, 3'b111, 0, 0, 8'hA5, 1, 0);
    add(1, 3'b111, 0, 0, 8'hA5, 1, 0);
    // Sweep left up to 00100000, then hazard at div 1, then reset mid-hazard
    add(1, 3'b011, 0, 0, 8'h00, 0, 0);
    add(1, 3'b011, 0, 0, 8'h10, 1, 0);
    add(1, 3'b011, 0, 0, 8'h20, 1, 0);
    add(1, 3'b100, 1, 0, 8'h00, 0, 0);
    add(1, 3'b100, 1, 0, 8'h00, 0, 0);
    add(1, 3'b100, 1, 0, 8'hFF, 1, 0);
    add(1, 3'b100, 1, 0, 8'hFF, 0, 0);
    add(1, 3'b100, 1, 0, 8'h00, 1, 0);
    add(1, 3'b100, 1, 0, 8'h00, 0, 0);
    add(1, 3'b100, 1, 0, 8'hFF, 1, 0);
    add(0, 3'b100, 1, 0, 8'h00, 0, 0);
    // Glitch 010 -> 011 -> 010 restarts the sweep from blank
    add(1, 3'b010, 0, 0, 8'h00, 0, 0);
    add(1, 3'b010, 0, 0, 8'h08, 1, 0);
    add(1, 3'b010, 0, 0, 8'h04, 1, 0);
    add(1, 3'b011, 0, 0, 8'h00, 0, 0);
    add(1, 3'b010, 0, 0, 8'h00, 0, 0);
    add(1, 3'b010, 0, 0, 8'h08, 1, 0);

    #2;
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].mode, vecs[i].div, vecs[i].bl);
      check($sformatf("v%0d.led", i), 32'(bus.led), 32'(vecs[i].led));
      check($sformatf("v%0d.tick", i), 32'(bus.tick), 32'(vecs[i].tick));
      check($sformatf("v%0d.done", i), 32'(bus.done), 32'(vecs[i].done));
    end

    // Lowering div mid-count: presc at 7 with div 10, then div 2 steps at once
    step(0, 3'b000, 10, 0);
    check("divdrop.reset_tick", 32'(bus.tick), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step(1, 3'b000, 10, 0);
      check($sformatf("divdrop.count%0d", i), 32'(bus.tick), 32'd0);
    end
    step(1, 3'b000, 2, 0);
    check("divdrop.first_tick", 32'(bus.tick), 32'd1);
    step(1, 3'b000, 2, 0);
    check("divdrop.gap1", 32'(bus.tick), 32'd0);
    step(1, 3'b000, 2, 0);
    check("divdrop.gap2", 32'(bus.tick), 32'd0);
    step(1, 3'b000, 2, 0);
    check("divdrop.second_tick", 32'(bus.tick), 32'd1);
    check("divdrop.led", 32'(bus.led), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
